pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Fetch-stage controller for the PC register. Each cycle it produces the next-PC value and write
//  enable, taken from the PC register's current value and the pipeline's hazard, branch, jump and
//  instruction-memory signals. Sits between the hazard/branch logic and the PC, and drives the
//  IF/ID flush and stall controls. Holds pending redirects across memory waits and counts stalls.
// PARAMETERS
//  ADDR_W      32  PC width in bits
//  RESET_PC    0   PC value presented at reset / before start
//  INSTR_BYTES 4   sequential increment added to the PC
//  CNT_W       16  width of the saturating stall counter
// PORTS
//  clk_i            in   1       clock; all state updates on the rising edge
//  rst_i            in   1       reset, synchronous, active-low
//  start_i          in   1       level; 1 = CPU enabled to fetch
//  pc_cur_i         in   ADDR_W  current PC register value
//  hazard_stall_i   in   1       load-use hazard: hold the PC and IF/ID
//  branch_taken_i   in   1       taken branch resolved this cycle
//  branch_target_i  in   ADDR_W  branch target
//  jump_i           in   1       jump resolved this cycle
//  jump_target_i    in   ADDR_W  jump target
//  imem_ready_i     in   1       instruction memory returned the fetch at pc_cur_i
//  pc_next_o        out  ADDR_W  value for the PC register input (combinational)
//  pc_write_o       out  1       PC write enable (combinational)
//  ifid_flush_o     out  1       turn the IF/ID contents into a bubble (combinational)
//  ifid_stall_o     out  1       hold IF/ID (combinational)
//  stall_cnt_o      out  CNT_W   cycles with pc_write_o=0 while in RUN/WAIT_MEM, saturating (registered)
// BEHAVIOUR
//  States: IDLE, RUN, WAIT_MEM. State, stall_cnt_o, pend_vld and pend_pc are registered.
//  Reset (rst_i=0 at an edge): state=IDLE, pend_vld=0, pend_pc=RESET_PC, stall_cnt_o=0.
//   While rst_i=0: pc_next_o=RESET_PC; pc_write_o, ifid_flush_o and ifid_stall_o are all 0.
//   Reset applied mid-operation discards any pending redirect.
//  IDLE: pc_write_o=0, pc_next_o=RESET_PC. Moves to RUN at the edge where start_i=1.
//  RUN, priority order (highest first) for pc_next_o / pc_write_o:
//   1 jump_i=1: jump_target_i, write=1, ifid_flush_o=1 (jump wins over branch if both are set)
//   2 branch_taken_i=1: branch_target_i, write=1, ifid_flush_o=1
//   3 hazard_stall_i=1: write=0, ifid_stall_o=1
//   4 imem_ready_i=0: write=0, ifid_stall_o=1, next state WAIT_MEM
//   5 otherwise: pc_cur_i+INSTR_BYTES, write=1. The addition wraps modulo 2^ADDR_W.
//  Redirect (case 1 or 2) while imem_ready_i=0:
//   - pend_pc is loaded with the target and pend_vld is set to 1
//   - write=0, ifid_flush_o=1, next state WAIT_MEM
//   - the target is not lost
//  WAIT_MEM:
//   - while imem_ready_i=0: write=0, ifid_stall_o=1
//   - a new jump/branch overwrites pend_pc; the latest redirect wins
//   - when imem_ready_i=1: return to RUN, write=1, pc_next_o = pend_vld ? pend_pc : pc_cur_i+INSTR_BYTES
//   - if pend_vld=1 on that cycle: ifid_flush_o=1 and pend_vld is cleared
//   - hazard_stall_i=1 on the ready cycle: hold the PC, stay in RUN, keep pend_vld until it is used
//  start_i=0 in RUN/WAIT_MEM: write=0, state and pend_vld are held. Outputs freeze; nothing is
//   flushed. Fetch resumes when start_i=1.
//  ifid_flush_o and ifid_stall_o are never both 1; flush takes precedence.
//  stall_cnt_o increments by 1 at each edge with start_i=1, state!=IDLE and pc_write_o=0. It saturates at all-ones.
//  Latency: a redirect presented in cycle N updates the PC at the end of cycle N (0 extra cycles).
// TESTING
//  1 reset then start_i=1, imem_ready_i=1, pc_cur_i tracks pc_next_o ->
//    PC sequence 0,4,8,12; stall_cnt_o=0
//  2 hazard_stall_i=1 for 2 cycles at PC=8 -> pc_write_o=0 and ifid_stall_o=1 for 2 cycles;
//    then PC=12; stall_cnt_o=2
//  3 branch_taken_i=1 and jump_i=1 together, targets 0x40 and 0x80 -> pc_next_o=0x80; ifid_flush_o=1
//  4 branch to 0x100 with imem_ready_i=0, ready 3 cycles later -> PC held;
//    on the ready cycle PC=0x100 and ifid_flush_o=1
//  5 in WAIT_MEM, jump to 0x200 then jump to 0x300 -> when ready, PC=0x300
//  6 pc_cur_i=0xFFFFFFFC and step -> PC=0; rst_i=0 during WAIT_MEM with a pending redirect ->
//    IDLE, PC=RESET_PC, redirect dropped; stall counter saturates at 0xFFFF

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: picks the next PC from sequential, branch, jump and held redirect
// sources, holds redirects across instruction-memory waits and counts stalled fetch cycles.
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_cur_i,
    input  logic              hazard_stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              pc_write_o,
    output logic              ifid_flush_o,
    output logic              ifid_stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_MEM} state_e;

    state_e            state_q, state_d;
    logic              pendVld_q, pendVld_d;
    logic [ADDR_W-1:0] pendPc_q, pendPc_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic              redirect;
    logic [ADDR_W-1:0] redirectTarget;
    logic [ADDR_W-1:0] seqPc;
    logic              holdHazard;

    assign redirect       = jump_i | branch_taken_i;
    assign redirectTarget = jump_i ? jump_target_i : branch_target_i;
    assign seqPc          = pc_cur_i + ADDR_W'(INSTR_BYTES);
    // A hazard only holds the PC once the fetch itself is back (or never left RUN).
    assign holdHazard     = hazard_stall_i & ((state_q == RUN) | imem_ready_i);
    assign stall_cnt_o    = stallCnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            pendVld_q  <= 1'b0;
            pendPc_q   <= RESET_PC;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pendVld_q  <= pendVld_d;
            pendPc_q   <= pendPc_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pendVld_d  = pendVld_q;
        pendPc_d   = pendPc_q;
        stallCnt_d = stallCnt_q;
        if (state_q == IDLE) begin
            if (start_i) state_d = RUN;
        end else if (start_i) begin
            if (redirect) begin
                if (imem_ready_i) begin
                    state_d   = RUN;
                    pendVld_d = 1'b0;
                end else begin
                    state_d   = WAIT_MEM;
                    pendVld_d = 1'b1;
                    pendPc_d  = redirectTarget;
                end
            end else if (holdHazard) begin
                state_d = RUN;
            end else if (!imem_ready_i) begin
                state_d = WAIT_MEM;
            end else begin
                state_d   = RUN;
                pendVld_d = 1'b0;
            end
            if (!pc_write_o && (stallCnt_q != {CNT_W{1'b1}})) begin
                stallCnt_d = stallCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pc_next_o    = RESET_PC;
        pc_write_o   = 1'b0;
        ifid_flush_o = 1'b0;
        ifid_stall_o = 1'b0;
        if (rst_i && (state_q != IDLE)) begin
            if (!start_i) begin
                pc_next_o    = pc_cur_i;
                ifid_stall_o = 1'b1;
            end else if (redirect) begin
                pc_next_o    = redirectTarget;
                pc_write_o   = imem_ready_i;
                ifid_flush_o = 1'b1;
            end else if (holdHazard || !imem_ready_i) begin
                pc_next_o    = pc_cur_i;
                ifid_stall_o = 1'b1;
            end else begin
                pc_next_o    = pendVld_q ? pendPc_q : seqPc;
                pc_write_o   = 1'b1;
                ifid_flush_o = pendVld_q;
            end
        end
    end

endmodule
